fir_seq_ctrl: RTL and testbench
===============================

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter TAPS, default 8: FIR tap count, i.e. zero samples injected per flush.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from fir_x_vld to the matching fir_y; range 1..8.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO entries, power of two.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 enable  input 1: run request; 0 requests a return to IDLE.
REQ-006 flush_req  input 1: single-cycle request to clear FIR history.
REQ-007 decim  input 2: decimation; every (decim+1)-th FIR result is kept.
REQ-008 in_valid  input 1: in_data is valid.
REQ-009 in_data  input 8: signed sample.
REQ-010 in_ready  output 1: controller accepts in_data this cycle.
REQ-011 fir_x  output 8: sample to the FIR datapath.
REQ-012 fir_x_vld  output 1: fir_x is valid this cycle.
REQ-013 fir_y  input 16: FIR result.
REQ-014 out_valid  output 1: out_data is valid.
REQ-015 out_data  output 16: kept FIR result, the FIFO head.
REQ-016 out_ready  input 1: consumer pops the FIFO head.
REQ-017 state  output 2: 0=IDLE, 1=FLUSH, 2=RUN, 3=DRAIN.
REQ-018 busy  output 1: state!=IDLE or in-flight!=0.

Function
REQ-019 Input handshake: a transfer occurs on in_valid&&in_ready.
REQ-020 fir_x and fir_x_vld SHALL be registered.
  - A transfer in cycle t drives fir_x=in_data, fir_x_vld=1 in cycle t+1.
REQ-021 fir_y for an issue at cycle t+1 SHALL be sampled at cycle t+1+LATENCY.
  - Tracking: a LATENCY-deep shift register of {vld,keep} bits.
REQ-022 keep SHALL be 1 only for RUN samples whose decimation counter equals 0.
  - Counter wraps at decim.
  - Counter advances on every RUN transfer.
REQ-023 Kept results SHALL be pushed into the FIFO; out_valid SHALL rise the cycle after the push (t+2+LATENCY).
REQ-024 Credit rule: in_ready=1 only in RUN with fifo_count + kept_in_flight + kept_issue_pending < DEPTH.
  - The FIFO therefore never overflows.
  - No kept result is ever dropped.
REQ-025 Simultaneous push and pop SHALL be legal at every occupancy including full; count is unchanged.
REQ-026 out_data SHALL be stable while out_valid&&!out_ready.
REQ-027 IDLE->FLUSH when enable=1.
REQ-028 FLUSH SHALL issue TAPS consecutive fir_x=0, fir_x_vld=1 with keep=0, then go to RUN.
  - in_ready=0 throughout FLUSH.
REQ-029 Entry to RUN SHALL latch decim and clear the decimation counter.
  - decim changes during RUN are ignored.
REQ-030 RUN->FLUSH on flush_req=1.
  - A transfer in that same cycle still completes with its keep bit.
  - In-flight kept results still reach the FIFO.
REQ-031 RUN->DRAIN when enable=0 and flush_req=0; flush_req has priority over enable=0.
REQ-032 DRAIN->IDLE when in-flight count=0.
  - in_ready=0 in DRAIN and IDLE.
  - FIFO contents remain poppable.
REQ-033 flush_req SHALL be ignored outside RUN.
REQ-034 Width rule: fir_y is passed through unmodified; no rounding or saturation.

Reset
REQ-035 rst=1 at any clock edge SHALL force all of the following, including mid-FLUSH or mid-RUN:
  - state=IDLE.
  - in_ready=0, fir_x=0, fir_x_vld=0.
  - out_valid=0, out_data=0, busy=0.
  - FIFO empty, shift register cleared, flush counter=0, decimation counter=0.
  - In-flight results are discarded.
REQ-036 The first cycle after rst deasserts SHALL be IDLE regardless of enable.

Verification
REQ-037 TAPS=8, LATENCY=2. Reset, then enable=1.
  - Required: state 1 for 8 cycles with fir_x=0 and fir_x_vld=1, then state=2 and in_ready=1.
  - Required: no FIFO push.
REQ-038 decim=0 in RUN. Feed 1..6 with out_ready=1 and the FIR model echoing fir_x*3.
  - Required: out_data 3,6,...,18 in order, each 4 cycles after acceptance.
REQ-039 decim=2. Feed 1..9.
  - Required: exactly 3 outputs, for samples 1, 4 and 7.
REQ-040 out_ready=0, continuous in_valid, decim=0.
  - Required: exactly 4 transfers, then in_ready=0; FIFO holds 4 with no loss.
  - Then out_ready=1: all 4 popped in order and in_ready returns.
REQ-041 flush_req in the same cycle as a transfer of 5.
  - Required: the result for 5 is delivered, then 8 zero issues, then RUN.
REQ-042 rst mid-RUN with 2 in flight and 2 in the FIFO.
  - Required: next cycle state=0, out_valid=0, busy=0.
  - Required: no late FIFO push.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// Sequencing controller for an external FIR datapath: flushes history with zero samples,
// decimates results, and buffers kept results in a credit-protected output FIFO.
module fir_seq_ctrl #(
    parameter int TAPS    = 8,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush_req,
    input  logic [1:0]  decim,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [7:0]  fir_x,
    output logic        fir_x_vld,
    input  logic [15:0] fir_y,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic [1:0]  state,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int FW = $clog2(TAPS + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = AW + 1;
    localparam int CW = $clog2(DEPTH + LATENCY + 2) + 1;

    logic [FW-1:0]      flush_cnt;
    logic [1:0]         dec_cnt;
    logic [1:0]         decim_lat;
    logic               keep_issue;
    logic [LATENCY-1:0] sr_vld;
    logic [LATENCY-1:0] sr_keep;
    logic [15:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [NW-1:0]      fifo_count;
    logic [CW-1:0]      credit_used;
    logic               xfer;
    logic               push;
    logic               pop;
    logic               inflight;

    // Every kept result already issued or in the FIR pipe holds a reserved FIFO slot.
    always_comb begin
        credit_used = CW'(fifo_count) + CW'(fir_x_vld & keep_issue);
        for (int i = 0; i < LATENCY; i++) begin
            credit_used = credit_used + CW'(sr_vld[i] & sr_keep[i]);
        end
    end

    assign in_ready  = (state == S_RUN) && (credit_used < CW'(DEPTH));
    assign xfer      = in_valid && in_ready;
    assign push      = sr_vld[LATENCY-1] && sr_keep[LATENCY-1];
    assign pop       = out_valid && out_ready;
    assign inflight  = fir_x_vld || (|sr_vld);
    assign busy      = (state != S_IDLE) || inflight;
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
            dec_cnt   <= '0;
            decim_lat <= '0;
            fir_x     <= '0;
            fir_x_vld <= 1'b0;
            keep_issue <= 1'b0;
        end else begin
            fir_x_vld  <= 1'b0;
            keep_issue <= 1'b0;
            if (xfer) begin
                fir_x      <= in_data;
                fir_x_vld  <= 1'b1;
                keep_issue <= (dec_cnt == 2'd0);
                dec_cnt    <= (dec_cnt == decim_lat) ? 2'd0 : dec_cnt + 2'd1;
            end
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state     <= S_FLUSH;
                        fir_x     <= '0;
                        fir_x_vld <= 1'b1;
                        flush_cnt <= FW'(1);
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == FW'(TAPS)) begin
                        state     <= S_RUN;
                        decim_lat <= decim;
                        dec_cnt   <= 2'd0;
                    end else begin
                        fir_x     <= '0;
                        fir_x_vld <= 1'b1;
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                S_RUN: begin
                    // A sample accepted alongside flush_req occupies the first flush issue slot.
                    if (flush_req) begin
                        state <= S_FLUSH;
                        if (xfer) begin
                            flush_cnt <= '0;
                        end else begin
                            fir_x     <= '0;
                            fir_x_vld <= 1'b1;
                            flush_cnt <= FW'(1);
                        end
                    end else if (!enable) begin
                        state <= S_DRAIN;
                    end
                end
                default: begin
                    if (!inflight) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_vld  <= '0;
            sr_keep <= '0;
        end else begin
            sr_vld[0]  <= fir_x_vld;
            sr_keep[0] <= fir_x_vld & keep_issue;
            for (int i = 1; i < LATENCY; i++) begin
                sr_vld[i]  <= sr_vld[i-1];
                sr_keep[i] <= sr_keep[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fir_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + NW'(1);
                2'b01:   fifo_count <= fifo_count - NW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: reset/flush vector table plus directed sequences for
// decimation, FIFO backpressure, flush-with-transfer, mid-run reset and drain.
module tb_fir_seq_ctrl;

    localparam int TAPS = 8;
    localparam int LAT  = 2;
    localparam int DEP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush_req;
    logic [1:0]  decim;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  fir_x;
    logic        fir_x_vld;
    logic [15:0] fir_y;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [1:0]  state;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0]  acc_q [$];
    int          acc_c [$];
    logic [15:0] pop_q [$];
    int          pop_c [$];
    logic [15:0] y_pipe [LAT];

    typedef struct {
        logic       rst;
        logic       enable;
        logic [1:0] exp_state;
        logic       exp_in_ready;
        logic       exp_vld;
        logic       exp_busy;
        logic       exp_out_valid;
    } vec_t;

    vec_t vecs [13];

    fir_seq_ctrl #(.TAPS(TAPS), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush_req(flush_req), .decim(decim),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fir_x(fir_x), .fir_x_vld(fir_x_vld), .fir_y(fir_y),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .state(state), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIR stand-in: y = 3*x, valid LAT cycles after the issue cycle
    always @(posedge clk) begin
        y_pipe[0] <= {{8{fir_x[7]}}, fir_x} * 16'd3;
        for (int i = 1; i < LAT; i++) y_pipe[i] <= y_pipe[i-1];
    end
    assign fir_y = y_pipe[LAT-1];

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                acc_q.push_back(in_data);
                acc_c.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                pop_q.push_back(out_data);
                pop_c.push_back(cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst    = v.rst;
        enable = v.enable;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearQueues();
        acc_q.delete();
        acc_c.delete();
        pop_q.delete();
        pop_c.delete();
    endtask

    task automatic waitState(input string name, input logic [1:0] target, input int budget);
        int n = 0;
        while (state != target && n < budget) begin
            step();
            n++;
        end
        checkOutput(name, 32'(state), 32'(target));
    endtask

    task automatic feedSample(input logic [7:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        checkOutput("feed_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic goFlush(input logic [1:0] d);
        decim     = d;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        waitState("flush_to_run", 2'd2, 30);
    endtask

    // Expected kept results for samples 1..n fed right after entering RUN with decimation d
    task automatic checkKept(input string tag, input int d, input int n);
        int exp_q [$];
        for (int k = 0; k < n; k++) begin
            if (k % (d + 1) == 0) exp_q.push_back(3 * (k + 1));
        end
        checkOutput({tag, "_count"}, 32'(pop_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(pop_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int n;
        int zeros;

        vecs[0] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 2; i <= 9; i++)  vecs[i] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 10; i <= 12; i++) vecs[i] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; enable = 1'b0; flush_req = 1'b0; decim = 2'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);

        // Reset, then enable: eight zero issues in FLUSH, then RUN with no FIFO push
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            checkOutput($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
            checkOutput($sformatf("row%0d_fir_x_vld", i), 32'(fir_x_vld), 32'(vecs[i].exp_vld));
            checkOutput($sformatf("row%0d_fir_x", i), 32'(fir_x), 32'd0);
            checkOutput($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_valid));
            checkOutput($sformatf("row%0d_out_data", i), 32'(out_data), 32'd0);
        end

        // decim=0: every sample kept, each popped 4 cycles after acceptance
        step();
        clearQueues();
        out_ready = 1'b1;
        for (int v = 1; v <= 6; v++) feedSample(8'(v));
        repeat (10) step();
        checkKept("dec0", 0, 6);
        for (int i = 0; i < 6 && i < pop_c.size() && i < acc_c.size(); i++) begin
            checkOutput($sformatf("dec0_latency%0d", i), 32'(pop_c[i] - acc_c[i]), 32'd4);
        end

        // decim=2 latched on RUN entry: keep samples 1, 4, 7
        goFlush(2'd2);
        clearQueues();
        for (int v = 1; v <= 9; v++) feedSample(8'(v));
        repeat (12) step();
        checkKept("dec2", 2, 9);

        // Backpressure: credits stop intake at DEPTH, nothing is lost
        goFlush(2'd0);
        clearQueues();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(10 + acc_q.size());
            step();
        end
        in_valid = 1'b0;
        checkOutput("bp_transfers", 32'(acc_q.size()), 32'd4);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_head", 32'(out_data), 32'd30);
        repeat (3) step();
        checkOutput("bp_head_stable", 32'(out_data), 32'd30);
        out_ready = 1'b1;
        repeat (8) step();
        checkOutput("bp_pops", 32'(pop_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < pop_q.size(); i++) begin
            checkOutput($sformatf("bp_pop%0d", i), 32'(pop_q[i]), 32'(30 + 3 * i));
        end
        checkOutput("bp_ready_back", 32'(in_ready), 32'd1);

        // flush_req coincident with the transfer of 5
        clearQueues();
        checkOutput("fl_pre_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = 8'd5;
        flush_req = 1'b1;
        step();
        in_valid  = 1'b0;
        flush_req = 1'b0;
        checkOutput("fl_state", 32'(state), 32'd1);
        checkOutput("fl_issue_vld", 32'(fir_x_vld), 32'd1);
        checkOutput("fl_issue_x", 32'(fir_x), 32'd5);
        zeros = 0;
        n = 0;
        while (state != 2'd2 && n < 20) begin
            step();
            n++;
            if (state == 2'd1 && fir_x_vld && fir_x == 8'd0) zeros++;
        end
        checkOutput("fl_zero_issues", 32'(zeros), 32'd8);
        checkOutput("fl_back_to_run", 32'(state), 32'd2);
        repeat (4) step();
        checkOutput("fl_pops", 32'(pop_q.size()), 32'd1);
        if (pop_q.size() > 0) checkOutput("fl_result5", 32'(pop_q[0]), 32'd15);

        // Reset mid-RUN with two results in the FIFO and two in flight
        clearQueues();
        out_ready = 1'b0;
        n = 0;
        while (acc_q.size() < 4 && n < 20) begin
            in_valid = 1'b1;
            in_data  = 8'(20 + acc_q.size());
            step();
            n++;
        end
        in_valid = 1'b0;
        step();
        checkOutput("rst_pre_out_valid", 32'(out_valid), 32'd1);
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        rst    = 1'b1;
        enable = 1'b0;
        step();
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_fir_x_vld", 32'(fir_x_vld), 32'd0);
        checkOutput("rst_fir_x", 32'(fir_x), 32'd0);
        rst = 1'b0;
        repeat (6) step();
        checkOutput("rst_no_late_push", 32'(out_valid), 32'd0);
        checkOutput("rst_idle_hold", 32'(state), 32'd0);

        // Drain: enable drop after one sample waits for it, then IDLE
        enable = 1'b1;
        waitState("drain_run", 2'd2, 30);
        clearQueues();
        out_ready = 1'b1;
        feedSample(8'd7);
        enable = 1'b0;
        step();
        checkOutput("drain_state", 32'(state), 32'd3);
        checkOutput("drain_busy", 32'(busy), 32'd1);
        waitState("drain_idle", 2'd0, 20);
        checkOutput("drain_busy_done", 32'(busy), 32'd0);
        checkOutput("drain_pops", 32'(pop_q.size()), 32'd1);
        if (pop_q.size() > 0) checkOutput("drain_result", 32'(pop_q[0]), 32'd21);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
